// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin scheduler sharing one serial 10111 detector among requesters
// Optional feature macro: SEQ_DET_SCHED_EARLY_EXIT_EN (end a frame at its first detection)
module seq_det_sched #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int DRAIN     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*FRAME_LEN-1:0] frame_data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       busy_o,
  output logic                       det_clr_n_o,
  output logic                       det_data_o,
  input  logic                       det_hit_i,
  output logic                       done_o,
  output logic [$clog2(N_REQ)-1:0]   done_id_o,
  output logic                       hit_o,
  output logic [CNT_W-1:0]           hit_cnt_o
);
  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(FRAME_LEN + DRAIN);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_REPORT} state_t;

  state_t                 state_q;
  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         cur_q;
  logic [FRAME_LEN-1:0]   shreg_q;
  logic [BCW-1:0]         bitcnt_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [N_REQ-1:0]       gnt_q;
  logic                   busy_q;
  logic                   det_clr_n_q;
  logic                   det_data_q;
  logic                   done_q;
  logic [IDW-1:0]         done_id_q;
  logic                   hit_q;
  logic [CNT_W-1:0]       hit_cnt_q;

  logic                   sel_found;
  logic [IDW-1:0]         sel_idx;
  logic [IDW-1:0]         cand;
  logic [FRAME_LEN-1:0]   frm [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_frm
    assign frm[g] = frame_data_i[g*FRAME_LEN +: FRAME_LEN];
  end

  // Search starts just after the last served requester, so it gets lowest priority next.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (det_hit_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(N_REQ - 1);
      cur_q       <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      det_clr_n_q <= 1'b0;
      det_data_q  <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hit_q       <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          det_clr_n_q <= 1'b1;
          det_data_q  <= 1'b0;
          if (sel_found) begin
            gnt_q       <= N_REQ'(1) << sel_idx;
            cur_q       <= sel_idx;
            shreg_q     <= frm[sel_idx];
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            det_clr_n_q <= 1'b0;
            state_q     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          det_clr_n_q <= 1'b1;
          det_data_q  <= shreg_q[FRAME_LEN-1];
          shreg_q     <= shreg_q << 1;
          bitcnt_q    <= '0;
          state_q     <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt_q      <= cnt_d;
          bitcnt_q   <= bitcnt_q + 1'b1;
          det_data_q <= shreg_q[FRAME_LEN-1];
          shreg_q    <= shreg_q << 1;
          if (bitcnt_q == BCW'(FRAME_LEN - 1)) begin
            det_data_q <= 1'b0;
            bitcnt_q   <= '0;
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_q      <= cnt_d;
          bitcnt_q   <= bitcnt_q + 1'b1;
          det_data_q <= 1'b0;
          if (bitcnt_q == BCW'(DRAIN - 1)) begin
            gnt_q     <= '0;
            done_q    <= 1'b1;
            done_id_q <= cur_q;
            hit_q     <= (cnt_d != '0);
            hit_cnt_q <= cnt_d;
            state_q   <= S_REPORT;
          end
        end
        S_REPORT: begin
          ptr_q   <= cur_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef SEQ_DET_SCHED_EARLY_EXIT_EN
      if (((state_q == S_SHIFT) || (state_q == S_DRAIN)) && det_hit_i) begin
        det_data_q <= 1'b0;
        gnt_q      <= '0;
        done_q     <= 1'b1;
        done_id_q  <= cur_q;
        hit_q      <= 1'b1;
        hit_cnt_q  <= CNT_W'(1);
        state_q    <= S_REPORT;
      end
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;
  assign det_clr_n_o = det_clr_n_q;
  assign det_data_o  = det_data_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign hit_o       = hit_q;
  assign hit_cnt_o   = hit_cnt_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - scoreboard bench for seq_det_sched with a 10111 detector stand-in
module tb_seq_det_sched;
  localparam int NR = 4;
  localparam int FL = 16;
  localparam int DR = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [63:0]   frame_data = '0;
  logic [NR-1:0] gnt;
  logic          busy;
  logic          det_clr_n;
  logic          det_data;
  logic          det_hit;
  logic          done;
  logic [1:0]    done_id;
  logic          hit;
  logic [CW-1:0] hit_cnt;
  logic [4:0]    hist = '0;

  int total = 0;
  int bad = 0;
  int mptr = NR - 1;

  typedef struct packed {
    logic [1:0] id;
    logic       hit;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_det_sched #(.N_REQ(NR), .FRAME_LEN(FL), .DRAIN(DR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .frame_data_i(frame_data),
    .gnt_o(gnt), .busy_o(busy), .det_clr_n_o(det_clr_n), .det_data_o(det_data),
    .det_hit_i(det_hit), .done_o(done), .done_id_o(done_id), .hit_o(hit), .hit_cnt_o(hit_cnt)
  );

  // Overlapping Moore detector: output is high while the last five bits read 10111.
  always @(posedge clk) begin
    if (!det_clr_n) hist <= '0;
    else            hist <= {hist[3:0], det_data};
  end
  assign det_hit = (hist == 5'b10111);

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_pat(input logic [15:0] f);
    int c = 0;
    logic [15:0] t;
    for (int i = 0; i <= 11; i++) begin
      t = f >> i;
      if (t[4:0] == 5'b10111) c++;
    end
    return c;
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    int j;
    for (int k = 1; k <= NR; k++) begin
      j = (p + k) % NR;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_frame();
    logic [15:0] f;
    f = 16'($urandom);
    if ($urandom_range(0, 1) == 1) f = f | (16'h0017 << $urandom_range(0, 11));
    return f;
  endfunction

  function automatic logic [63:0] rand_frames();
    return {rand_frame(), rand_frame(), rand_frame(), rand_frame()};
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (gnt != '0) chk("gnt_onehot", longint'($onehot(gnt)), 1);
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_id", done_id, e.id);
          chk("hit", hit, e.hit);
          chk("hit_cnt", hit_cnt, e.cnt);
        end
      end
    end
  end

  task automatic run_frame(input logic [3:0] r, input logic [63:0] fr, input bit perturb, input int rst_at);
    int idx;
    int c;
    int lat;
    logic [15:0] f;
    exp_t e;
    req = r;
    frame_data = fr;
    idx = pick(r, mptr);
    f = 16'(fr >> (idx * 16));
    c = count_pat(f);
    for (int n = 0; n < 6 && gnt == '0; n++) @(negedge clk);
    if (gnt == '0) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    chk("gnt", gnt, 1 << idx);
    chk("clear_pulse", det_clr_n, 0);
    chk("busy", busy, 1);
    if (rst_at > 0) begin
      repeat (rst_at) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_det_clr_n", det_clr_n, 0);
      chk("rst_done", done, 0);
      repeat (3) begin
        @(negedge clk);
        chk("rst_no_done", done, 0);
      end
      rst_n = 1'b1;
      mptr = NR - 1;
      return;
    end
    e.id  = 2'(idx);
    e.hit = (c != 0);
`ifdef SEQ_DET_SCHED_EARLY_EXIT_EN
    e.cnt = (c != 0) ? 8'd1 : 8'd0;
`else
    e.cnt = 8'(c);
`endif
    exp_q.push_back(e);
    lat = 0;
`ifndef SEQ_DET_SCHED_EARLY_EXIT_EN
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      lat++;
      chk("det_data", det_data, int'(f >> (15 - k)) & 1);
      if (perturb && k == 6) begin
        req = 4'($urandom);
        frame_data = {$urandom, $urandom};
      end
    end
`endif
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
`ifndef SEQ_DET_SCHED_EARLY_EXIT_EN
    chk("latency", lat, FL + DR + 1);
`endif
    mptr = idx;
  endtask

  initial begin
    logic [3:0] r;
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_det_clr_n", det_clr_n, 0);
    chk("reset_det_data", det_data, 0);
    chk("reset_done", done, 0);
    chk("reset_done_id", done_id, 0);
    chk("reset_hit", hit, 0);
    chk("reset_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(4'b0001, {48'h0, 16'h0017}, 1'b0, 0);
    run_frame(4'b0100, {16'hffff, 16'h0000, 16'hffff, 16'hffff}, 1'b0, 0);
    run_frame(4'b0100, {16'h0000, 16'h1717, 16'h0000, 16'h0000}, 1'b0, 0);
    repeat (5) run_frame(4'b1111, rand_frames(), 1'b0, 0);
    run_frame(4'b0010, rand_frames(), 1'b0, 7);
    run_frame(4'b0001, {48'h0, 16'h0017}, 1'b0, 0);
    run_frame(4'b0010, {16'h0, 16'h0, 16'h2e17, 16'h0}, 1'b1, 0);
    for (int t = 0; t < 30; t++) begin
      r = 4'($urandom_range(1, 15));
      run_frame(r, rand_frames(), 1'($urandom_range(0, 1)), 0);
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
